// File: rtl/mux8_scan_ctrl_if.sv
// Bundle between the scan controller and its word producer / mux_8x1 tree.
//
// Handshake: a word transfers on a rising clk edge where load_valid and
// load_ready are both high. load_ready is only offered while the block is
// idle. A producer that sees load_ready low must keep load_valid and
// load_data stable until the transfer happens; the block never buffers an
// offered word.
interface mux8_scan_ctrl_if;
    logic       en;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       i0, i1, i2, i3, i4, i5, i6, i7;
    logic       s0, s1, s2;
    logic       slot_valid;
    logic       done;

    // Producer / testbench side
    modport master (
        output en, load_valid, load_data,
        input  load_ready, i0, i1, i2, i3, i4, i5, i6, i7,
        input  s0, s1, s2, slot_valid, done
    );

    // Scan controller side
    modport slave (
        input  en, load_valid, load_data,
        output load_ready, i0, i1, i2, i3, i4, i5, i6, i7,
        output s0, s1, s2, slot_valid, done
    );
endinterface

// File: rtl/mux8_scan_ctrl.sv
// Scan controller for a mux_8x1 tree: captures an 8-bit word, then walks the
// select lines 0..7 (each held HOLD_CYCLES enabled cycles) so the mux output
// serialises the word LSB-first. State and hold counter are exposed on debug
// ports so checkers can observe the FSM directly.
module mux8_scan_ctrl #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    mux8_scan_ctrl_if.slave bus,
    output logic          dbg_scan_o,
    output logic [7:0]    dbg_hold_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Last legal hold count; HOLD_CYCLES up to 256 still fits in 8 bits.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] data_q;
    logic [2:0] sel_q;
    logic [7:0] hold_q;

    logic       load_ready;
    logic       accept;
    logic       last_hold;
    logic       last_slot;

    assign last_hold = (hold_q == HOLD_LAST);
    assign last_slot = (sel_q == 3'd7);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave IDLE on an accepted word, leave SCAN after the last
    // enabled hold cycle of slot 7.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (bus.en && last_hold && last_slot) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: handshake ready, slot qualifier and end-of-frame pulse.
    always_comb begin
        load_ready = 1'b0;
        accept     = 1'b0;
        bus.slot_valid = 1'b0;
        bus.done       = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = !rst;
                accept     = bus.load_valid && !rst;
            end
            SCAN: begin
                bus.slot_valid = 1'b1;
                bus.done       = last_slot && last_hold && bus.en;
            end
            default: ;
        endcase
    end

    // Datapath: capture the word on accept, then advance hold/select while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= 8'd0;
            sel_q  <= 3'd0;
            hold_q <= 8'd0;
        end else if (accept) begin
            data_q <= bus.load_data;
            sel_q  <= 3'd0;
            hold_q <= 8'd0;
        end else if (state_q == SCAN && bus.en) begin
            if (!last_hold) begin
                hold_q <= hold_q + 8'd1;
            end else begin
                hold_q <= 8'd0;
                // Slot 7 exits to IDLE with select parked at 0; no wrap inside SCAN.
                sel_q  <= last_slot ? 3'd0 : sel_q + 3'd1;
            end
        end
    end

    assign bus.load_ready = load_ready;

    assign bus.i0 = data_q[0];
    assign bus.i1 = data_q[1];
    assign bus.i2 = data_q[2];
    assign bus.i3 = data_q[3];
    assign bus.i4 = data_q[4];
    assign bus.i5 = data_q[5];
    assign bus.i6 = data_q[6];
    assign bus.i7 = data_q[7];

    assign bus.s0 = sel_q[0];
    assign bus.s1 = sel_q[1];
    assign bus.s2 = sel_q[2];

    assign dbg_scan_o     = (state_q == SCAN);
    assign dbg_hold_cnt_o = hold_q;

endmodule
